// File: rtl/uart_ctrl_sched.sv
// -----------------------------------------------------------------------------
// uart_ctrl_sched
//
// Bus-side controller for the core's UART register port. After reset it
// programs BAUD once, then loops forever reading STAT (POLL presents the
// address, CHK consumes the registered read data). A pending RX byte is drained
// from RDR before anything else. N transmit requesters share the transmitter
// through a round-robin arbiter. Each granted byte is written to TDR and kicked
// with CTRL[0]. STAT[0] is then tracked: rising means the byte started, falling
// means it is done. A start that never shows within TIMEOUT cycles raises err.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous reset, active low
//   req          per-requester TX request, held with data stable until ack
//   req_data     byte of requester i at [8*i+7:8*i]
//   ack          one-cycle pulse, byte of requester i has been written to TDR
//   rx_valid     one-cycle pulse, rx_data holds a freshly received byte
//   rx_data      last received byte, held between pulses
//   busy         a TX transaction is in progress
//   err          one-cycle pulse when a kicked byte never started
//   uart_we      UART register write enable
//   uart_reg_num UART register select
//   uart_wd      UART write data
//   uart_rd      UART read data, valid the cycle after a read is presented
// -----------------------------------------------------------------------------
module uart_ctrl_sched #(
  parameter int          N             = 4,
  parameter logic [31:0] BAUD_DIV      = 32'd433,
  parameter logic [15:0] TIMEOUT       = 16'd4096,
  // UART register indices, matching the peripheral's register mux
  parameter logic [2:0]  UART_MUX_CTRL = 3'd0,
  parameter logic [2:0]  UART_MUX_STAT = 3'd1,
  parameter logic [2:0]  UART_MUX_BAUD = 3'd2,
  parameter logic [2:0]  UART_MUX_TDR  = 3'd3,
  parameter logic [2:0]  UART_MUX_RDR  = 3'd4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic           rx_valid,
  output logic [7:0]     rx_data,
  output logic           busy,
  output logic           err,
  output logic           uart_we,
  output logic [2:0]     uart_reg_num,
  output logic [31:0]    uart_wd,
  input  logic [31:0]    uart_rd
);

  localparam int              IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W:0]  N_W   = (IDX_W + 1)'(N);

  typedef enum logic [2:0] {
    S_BAUD,
    S_POLL,
    S_CHK,
    S_TDR,
    S_CTRL,
    S_RDR,
    S_RDW
  } state_t;

  typedef enum logic [1:0] {
    TX_NONE,
    TX_WAIT_START,
    TX_WAIT_DONE
  } tx_phase_t;

  state_t           r_state;
  tx_phase_t        r_tx_phase;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [7:0]       r_tx_byte;
  logic [15:0]      r_timer;
  logic [N-1:0]     r_ack;
  logic             r_rx_valid;
  logic [7:0]       r_rx_data;
  logic             r_err;

  logic [7:0]       w_req_byte [N];
  logic [IDX_W-1:0] w_cand     [N];
  logic [N-1:0]     w_gnt_onehot;
  logic             w_gnt_found;
  logic [IDX_W-1:0] w_gnt_sel;

  // STAT bits between RX-not-empty (31) and the byte lanes are not needed here.
  logic             w_unused_rd;
  assign w_unused_rd = ^uart_rd[30:8];

  // Per-requester byte lanes, the scan order of the arbiter, and the ack decode.
  // w_cand[gi] is the requester examined (gi+1) places after the last grant,
  // so the most recently served requester is always looked at last.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      logic [IDX_W:0] w_sum;
      assign w_req_byte[gi]   = req_data[8*gi +: 8];
      assign w_sum            = {1'b0, r_rr_ptr} + (IDX_W + 1)'(gi + 1);
      assign w_cand[gi]       = (w_sum >= N_W) ? IDX_W'(w_sum - N_W) : IDX_W'(w_sum);
      assign w_gnt_onehot[gi] = (r_gnt_idx == IDX_W'(gi));
    end
  endgenerate

  // Round-robin pick: first asserted request in scan order.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_sel   = r_rr_ptr;
    for (int k = 0; k < N; k++) begin
      if (!w_gnt_found && req[w_cand[k]]) begin
        w_gnt_found = 1'b1;
        w_gnt_sel   = w_cand[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_BAUD;
      r_tx_phase <= TX_NONE;
      r_rr_ptr   <= IDX_W'(N - 1);
      r_gnt_idx  <= '0;
      r_tx_byte  <= '0;
      r_timer    <= '0;
      r_ack      <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ack      <= '0;
      r_rx_valid <= 1'b0;
      r_err      <= 1'b0;

      // Start-timeout counter, saturating so the >= test in CHK stays true.
      if (r_tx_phase == TX_WAIT_START && r_timer < TIMEOUT) begin
        r_timer <= r_timer + 16'd1;
      end

      case (r_state)
        S_BAUD: r_state <= S_POLL;
        S_POLL: r_state <= S_CHK;
        S_CHK: begin
          // RX always wins; the TX bookkeeping is picked up on a later CHK.
          if (uart_rd[31]) begin
            r_state <= S_RDR;
          end else begin
            r_state <= S_POLL;
            case (r_tx_phase)
              TX_WAIT_START: begin
                if (uart_rd[0]) begin
                  r_tx_phase <= TX_WAIT_DONE;
                end else if (r_timer >= TIMEOUT) begin
                  r_err      <= 1'b1;
                  r_tx_phase <= TX_NONE;
                end
              end
              TX_WAIT_DONE: begin
                if (!uart_rd[0]) begin
                  r_tx_phase <= TX_NONE;
                end
              end
              default: begin
                if (w_gnt_found) begin
                  r_gnt_idx <= w_gnt_sel;
                  r_tx_byte <= w_req_byte[w_gnt_sel];
                  r_state   <= S_TDR;
                end
              end
            endcase
          end
        end
        S_TDR: begin
          // Loaded here so the pulse lines up with the CTRL write cycle.
          r_ack   <= w_gnt_onehot;
          r_state <= S_CTRL;
        end
        S_CTRL: begin
          r_rr_ptr   <= r_gnt_idx;
          r_tx_phase <= TX_WAIT_START;
          r_timer    <= '0;
          r_state    <= S_POLL;
        end
        S_RDR: r_state <= S_RDW;
        S_RDW: begin
          r_rx_data  <= uart_rd[7:0];
          r_rx_valid <= 1'b1;
          r_state    <= S_POLL;
        end
        default: r_state <= S_POLL;
      endcase
    end
  end

  // Register-port drive is a pure decode of the state. RDR is only ever
  // addressed in S_RDR because reading it pops the receive flag.
  always_comb begin
    uart_we      = 1'b0;
    uart_reg_num = UART_MUX_STAT;
    uart_wd      = 32'h0;
    case (r_state)
      S_BAUD: begin
        uart_we      = 1'b1;
        uart_reg_num = UART_MUX_BAUD;
        uart_wd      = BAUD_DIV;
      end
      S_TDR: begin
        uart_we      = 1'b1;
        uart_reg_num = UART_MUX_TDR;
        uart_wd      = {24'h0, r_tx_byte};
      end
      S_CTRL: begin
        uart_we      = 1'b1;
        uart_reg_num = UART_MUX_CTRL;
        uart_wd      = 32'h1;
      end
      S_RDR: begin
        uart_reg_num = UART_MUX_RDR;
      end
      default: begin
        uart_reg_num = UART_MUX_STAT;
      end
    endcase
  end

  assign busy     = (r_state == S_TDR) || (r_state == S_CTRL) || (r_tx_phase != TX_NONE);
  assign ack      = r_ack;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign err      = r_err;

endmodule

// File: tb/tb_uart_ctrl_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_ctrl_sched
//
// Drives uart_ctrl_sched against a small behavioural UART register model.
// Expected TX bytes and RX bytes are queued when stimulus is applied and
// popped as the DUT writes TDR or pulses rx_valid. Round-robin order comes
// from a vector table; reset, RX priority, start timeout and mid-transaction
// reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_ctrl_sched;

  localparam int         N      = 4;
  localparam logic [2:0] R_CTRL = 3'd0;
  localparam logic [2:0] R_STAT = 3'd1;
  localparam logic [2:0] R_BAUD = 3'd2;
  localparam logic [2:0] R_TDR  = 3'd3;
  localparam logic [2:0] R_RDR  = 3'd4;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic [N-1:0]   req      = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           rx_valid;
  logic [7:0]     rx_data;
  logic           busy;
  logic           err;
  logic           uart_we;
  logic [2:0]     uart_reg_num;
  logic [31:0]    uart_wd;
  logic [31:0]    uart_rd  = '0;

  always #5 clk = ~clk;

  uart_ctrl_sched #(
    .N             (N),
    .BAUD_DIV      (32'd433),
    .TIMEOUT       (16'd4096),
    .UART_MUX_CTRL (R_CTRL),
    .UART_MUX_STAT (R_STAT),
    .UART_MUX_BAUD (R_BAUD),
    .UART_MUX_TDR  (R_TDR),
    .UART_MUX_RDR  (R_RDR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .busy         (busy),
    .err          (err),
    .uart_we      (uart_we),
    .uart_reg_num (uart_reg_num),
    .uart_wd      (uart_wd),
    .uart_rd      (uart_rd)
  );

  // ---------------- UART register model ----------------
  int         m_start_delay = 10;   // 0 = transmitter never starts
  int         m_done_delay  = 200;
  logic       inj           = 1'b0;
  logic [7:0] inj_byte      = 8'h0;
  logic       m_rx_pend     = 1'b0;
  logic [7:0] m_rdr         = 8'h0;
  logic       m_tx_busy     = 1'b0;
  int         m_start_cnt   = 0;
  int         m_done_cnt    = 0;

  always @(posedge clk) begin
    case (uart_reg_num)
      R_STAT:  uart_rd <= {m_rx_pend, 30'h0, m_tx_busy};
      R_RDR:   uart_rd <= {24'h0, m_rdr};
      default: uart_rd <= 32'h0;
    endcase
    if (uart_we && uart_reg_num == R_CTRL && uart_wd[0] && m_start_delay > 0) begin
      m_start_cnt <= m_start_delay;
    end else if (m_start_cnt > 0) begin
      m_start_cnt <= m_start_cnt - 1;
      if (m_start_cnt == 1) begin
        m_tx_busy  <= 1'b1;
        m_done_cnt <= m_done_delay;
      end
    end
    if (m_done_cnt > 0) begin
      m_done_cnt <= m_done_cnt - 1;
      if (m_done_cnt == 1) m_tx_busy <= 1'b0;
    end
    if (!uart_we && uart_reg_num == R_RDR) m_rx_pend <= 1'b0;
    if (inj) begin
      m_rx_pend <= 1'b1;
      m_rdr     <= inj_byte;
    end
  end

  // ---------------- scoreboard and vector table ----------------
  typedef struct {
    int         idx;
    logic [7:0] data;
  } tx_exp_t;

  typedef struct {
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    int             exp_idx;
    logic [7:0]     exp_byte;
  } rr_vec_t;

  tx_exp_t    exp_q[$];
  logic [7:0] rx_q[$];
  rr_vec_t    rr_tab [7];

  int n_vec       = 0;
  int n_err       = 0;
  int cyc         = 0;
  int ack_cnt     = 0;
  int err_cnt     = 0;
  int rdr_cyc     = -1;
  int tdr_cyc     = -1;
  bit ack_due     = 1'b0;
  int due_idx     = 0;
  bit err_allowed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_tx(input int idx, input logic [7:0] b);
    tx_exp_t t;
    t.idx  = idx;
    t.data = b;
    exp_q.push_back(t);
  endtask

  // One clock: sample at the falling edge and run the output monitor.
  task automatic tick();
    tx_exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      ack_due = 1'b0;
    end else begin
      if (ack_due) begin
        chk("ack_pulse", ack, 64'(1) << due_idx);
        chk("ctrl_write", {uart_we, uart_reg_num, uart_wd}, {1'b1, R_CTRL, 32'h1});
        ack_due = 1'b0;
      end else if (ack != '0) begin
        chk("ack_spurious", ack, 0);
      end
      if (ack != '0) ack_cnt++;
      if (uart_we && uart_reg_num == R_TDR) begin
        tdr_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("tdr_unexpected", uart_we, 0);
        end else begin
          e = exp_q.pop_front();
          chk("tdr_wd", uart_wd, {24'h0, e.data});
          ack_due = 1'b1;
          due_idx = e.idx;
          $display("tx   : req %0d byte %02h at cycle %0d", e.idx, uart_wd[7:0], cyc);
        end
      end
      if (!uart_we && uart_reg_num == R_RDR) rdr_cyc = cyc;
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          chk("rx_unexpected", rx_valid, 0);
        end else begin
          chk("rx_data", rx_data, rx_q.pop_front());
          $display("rx   : byte %02h at cycle %0d", rx_data, cyc);
        end
      end
      if (err) begin
        err_cnt++;
        $display("err  : start timeout at cycle %0d", cyc);
        if (!err_allowed) chk("err_spurious", err, 0);
      end
    end
  endtask

  task automatic wait_ack(input int budget);
    int a0;
    int n;
    a0 = ack_cnt;
    n  = 0;
    while (ack_cnt == a0 && n < budget) begin
      tick();
      n++;
    end
    chk("ack_arrived", ack_cnt != a0, 1);
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("busy_cleared", busy, 0);
  endtask

  initial begin
    int n;
    int a0;
    int e0;

    // Held requests against rr_ptr=N-1 after reset, then masks that move the pointer.
    rr_tab[0] = '{4'b1011, 32'h44332211, 0, 8'h11};
    rr_tab[1] = '{4'b1011, 32'h44332211, 1, 8'h22};
    rr_tab[2] = '{4'b1011, 32'h44332211, 3, 8'h44};
    rr_tab[3] = '{4'b1011, 32'h44332211, 0, 8'h11};
    rr_tab[4] = '{4'b0100, 32'h88776655, 2, 8'h77};
    rr_tab[5] = '{4'b1001, 32'h88776655, 3, 8'h88};
    rr_tab[6] = '{4'b0011, 32'h88776655, 0, 8'h55};

    // ---- reset and start-up sequence ----
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    chk("baud_write", {uart_we, uart_reg_num, uart_wd}, {1'b1, R_BAUD, 32'd433});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stat_poll", {uart_we, uart_reg_num, uart_wd}, {1'b0, R_STAT, 32'h0});
    end

    // ---- round-robin table ----
    m_start_delay = 3;
    m_done_delay  = 20;
    for (int i = 0; i < 7; i++) begin
      req      = rr_tab[i].req;
      req_data = rr_tab[i].data;
      expect_tx(rr_tab[i].exp_idx, rr_tab[i].exp_byte);
      wait_ack(40);
      wait_idle(100, n);
    end
    req = '0;

    // ---- single request, busy tracks STAT[0] ----
    m_start_delay = 10;
    m_done_delay  = 200;
    repeat (3) tick();
    req      = 4'b0100;
    req_data = 32'h00A5_0000;
    expect_tx(2, 8'hA5);
    wait_ack(20);
    req = '0;
    chk("busy_at_ctrl", busy, 1);
    wait_idle(400, n);
    chk("busy_span_213", (n >= 211 && n <= 215), 1);

    // ---- RX pending together with a TX request ----
    m_done_delay = 20;
    repeat (3) tick();
    rdr_cyc  = -1;
    tdr_cyc  = -1;
    inj_byte = 8'h3C;
    inj      = 1'b1;
    rx_q.push_back(8'h3C);
    tick();
    inj = 1'b0;
    tick();
    req      = 4'b0001;
    req_data = 32'h0000_0077;
    expect_tx(0, 8'h77);
    wait_ack(30);
    req = '0;
    chk("rdr_before_tdr", (rdr_cyc >= 0 && rdr_cyc < tdr_cyc), 1);
    wait_idle(100, n);
    chk("rx_drained", rx_q.size(), 0);

    // ---- transmitter never starts: timeout ----
    m_start_delay = 0;
    repeat (3) tick();
    err_allowed = 1'b1;
    e0       = err_cnt;
    req      = 4'b1000;
    req_data = 32'hC300_0000;
    expect_tx(3, 8'hC3);
    wait_ack(20);
    req = '0;
    n = 0;
    while (err_cnt == e0 && n < 5000) begin
      tick();
      n++;
    end
    chk("err_arrived", err_cnt != e0, 1);
    chk("err_latency", (n >= 4096 && n <= 4104), 1);
    chk("busy_after_err", busy, 0);
    repeat (6) tick();
    chk("err_once", err_cnt - e0, 1);
    err_allowed = 1'b0;

    m_start_delay = 10;
    req      = 4'b0010;
    req_data = 32'h0000_5A00;
    expect_tx(1, 8'h5A);
    wait_ack(20);
    req = '0;
    wait_idle(200, n);

    // ---- reset while waiting for the byte to finish ----
    m_done_delay = 300;
    repeat (3) tick();
    req      = 4'b0100;
    req_data = 32'h0099_0000;
    expect_tx(2, 8'h99);
    wait_ack(20);
    req = '0;
    repeat (30) tick();
    chk("busy_wait_done", busy, 1);
    a0 = ack_cnt;
    e0 = err_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ack", ack, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_err", err, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    chk("midrst_baud", {uart_we, uart_reg_num, uart_wd}, {1'b1, R_BAUD, 32'd433});
    tick();
    chk("midrst_poll", {uart_we, uart_reg_num, uart_wd}, {1'b0, R_STAT, 32'h0});
    repeat (400) tick();
    chk("midrst_no_ack", ack_cnt, a0);
    chk("midrst_no_err", err_cnt, e0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
